cdp1802_cycle_seq: RTL and testbench

//  Parametrised machine-cycle sequencer for the CDP1802 core family. It generates the tick counter,
//  TPA/TPB timing pulses and S0..S3 state codes, and decodes the CLEAR_N/WAIT_N modes.
//  It arbitrates DMA-in, DMA-out and interrupt cycles between instructions. The core execute path

---
 rtl/cdp1802_cycle_seq.sv | 114 +++++++++++
 tb/tb_cdp1802_cycle_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cdp1802_cycle_seq.sv
// Machine-cycle sequencer for the CDP1802 family: tick counter, TPA/TPB pulses,
// S0..S3 state codes, CLEAR_N/WAIT_N mode decode and DMA/interrupt cycle arbitration.
module cdp1802_cycle_seq #(
  parameter  int TICKS_PER_CYCLE = 8,
  parameter  int TPA_TICK        = 1,
  parameter  int TPB_TICK        = 6,
  localparam int TW              = $clog2(TICKS_PER_CYCLE)
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          CLK_EN,
  input  logic          CLEAR_N,
  input  logic          WAIT_N,
  input  logic          DMA_IN_N,
  input  logic          DMA_OUT_N,
  input  logic          INT_N,
  input  logic          IE,
  input  logic          exec_last,
  output logic [1:0]    SC,
  output logic          TPA,
  output logic          TPB,
  output logic [TW-1:0] tick,
  output logic          cycle_end,
  output logic          dma_in_cyc,
  output logic          dma_out_cyc,
  output logic          int_ack,
  output logic [1:0]    mode
);
  localparam logic [TW-1:0] LAST  = TW'(TICKS_PER_CYCLE - 1);
  localparam logic [TW-1:0] TPA_T = TW'(TPA_TICK);
  localparam logic [TW-1:0] TPB_T = TW'(TPB_TICK);

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_EXEC, ST_DMAI, ST_DMAO, ST_INT
  } state_t;

  state_t        state, nxt_state;
  logic [1:0]    mode_in, nxt_sc;
  logic          run_m, load_m, active, sample;
  logic          dma_in_q, dma_out_q, int_q;
  logic [TW-1:0] nxt_tick;

  // Mode lines act on the clock they are seen, so a mode change beats a coincident cycle_end.
  assign mode_in   = {CLEAR_N, WAIT_N};
  assign run_m     = (mode_in == 2'b11);
  assign load_m    = (mode_in == 2'b00);
  assign active    = !RESET && (run_m || load_m);
  assign cycle_end = active && CLK_EN && (tick == LAST);
  assign sample    = active && CLK_EN && (tick == TPB_T);
  assign nxt_tick  = (tick == LAST) ? '0 : tick + 1'b1;

  always_comb begin
    nxt_state = ST_FETCH;
    if (load_m)
      nxt_state = dma_in_q ? ST_DMAI : ST_INIT;
    else if (state == ST_FETCH)
      nxt_state = ST_EXEC;
    else if (state == ST_EXEC && !exec_last)
      nxt_state = ST_EXEC;
    else if (dma_in_q)
      nxt_state = ST_DMAI;
    else if (dma_out_q)
      nxt_state = ST_DMAO;
    else if (int_q && IE && state != ST_INT)  // no back-to-back interrupt cycles
      nxt_state = ST_INT;
  end

  always_comb begin
    nxt_sc = 2'b01;
    case (nxt_state)
      ST_FETCH:         nxt_sc = 2'b00;
      ST_DMAI, ST_DMAO: nxt_sc = 2'b10;
      ST_INT:           nxt_sc = 2'b11;
      default:          nxt_sc = 2'b01;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || mode_in == 2'b01) begin
      state       <= ST_INIT;
      SC          <= 2'b01;
      tick        <= '0;
      TPA         <= 1'b0;
      TPB         <= 1'b0;
      dma_in_cyc  <= 1'b0;
      dma_out_cyc <= 1'b0;
      int_ack     <= 1'b0;
      dma_in_q    <= 1'b0;
      dma_out_q   <= 1'b0;
      int_q       <= 1'b0;
      mode        <= 2'b01;
    end else begin
      mode    <= mode_in;
      int_ack <= 1'b0;
      if (active && CLK_EN) begin
        tick <= nxt_tick;
        TPA  <= (nxt_tick == TPA_T);
        TPB  <= (nxt_tick == TPB_T);
      end
      if (sample) begin
        dma_in_q  <= ~DMA_IN_N;
        dma_out_q <= ~DMA_OUT_N;
        int_q     <= ~INT_N;
      end
      if (cycle_end) begin
        state       <= nxt_state;
        SC          <= nxt_sc;
        dma_in_cyc  <= (nxt_state == ST_DMAI);
        dma_out_cyc <= (nxt_state == ST_DMAO);
        int_ack     <= (nxt_state == ST_INT);
      end
    end
  end
endmodule

// File: tb/tb_cdp1802_cycle_seq.sv
// Bench for cdp1802_cycle_seq: directed scenarios then randomized traffic, all
// checked every clock against a cycle-level behavioural model.
module tb_cdp1802_cycle_seq;
  localparam int T = 8, TA = 1, TB = 6;
  localparam int K_INIT = 0, K_FETCH = 1, K_EXEC = 2, K_DMAI = 3, K_DMAO = 4, K_INT = 5;

  logic CLOCK, RESET, CLK_EN, CLEAR_N, WAIT_N, DMA_IN_N, DMA_OUT_N, INT_N, IE, exec_last;
  logic [1:0] SC, mode;
  logic [2:0] tick;
  logic TPA, TPB, cycle_end, dma_in_cyc, dma_out_cyc, int_ack;

  cdp1802_cycle_seq #(.TICKS_PER_CYCLE(T), .TPA_TICK(TA), .TPB_TICK(TB)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CLK_EN(CLK_EN), .CLEAR_N(CLEAR_N), .WAIT_N(WAIT_N),
    .DMA_IN_N(DMA_IN_N), .DMA_OUT_N(DMA_OUT_N), .INT_N(INT_N), .IE(IE), .exec_last(exec_last),
    .SC(SC), .TPA(TPA), .TPB(TPB), .tick(tick), .cycle_end(cycle_end),
    .dma_in_cyc(dma_in_cyc), .dma_out_cyc(dma_out_cyc), .int_ack(int_ack), .mode(mode));

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_pass = 0, n_total = 0;

  // model state
  int m_kind = K_INIT, m_tick = 0;
  bit m_tpa, m_tpb, m_dmai, m_dmao, m_ack, m_di, m_do, m_iq;
  logic [1:0] m_mode = 2'b01;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [1:0] sc_of(input int k);
    case (k)
      K_FETCH:        return 2'b00;
      K_DMAI, K_DMAO: return 2'b10;
      K_INT:          return 2'b11;
      default:        return 2'b01;
    endcase
  endfunction

  function automatic int next_kind(input int k, input bit load, input bit el);
    if (load) return m_di ? K_DMAI : K_INIT;
    if (k == K_FETCH) return K_EXEC;
    if (k == K_EXEC && !el) return K_EXEC;
    if (m_di) return K_DMAI;
    if (m_do) return K_DMAO;
    if (m_iq && IE && k != K_INT) return K_INT;
    return K_FETCH;
  endfunction

  function automatic bit exp_cycle_end();
    return !RESET && (CLEAR_N == WAIT_N) && CLK_EN && m_tick == T - 1;
  endfunction

  task automatic model_edge();
    logic [1:0] mi;
    bit ce, smp;
    int nk;
    mi = {CLEAR_N, WAIT_N};
    if (RESET || mi == 2'b01) begin
      m_kind = K_INIT; m_tick = 0; m_tpa = 0; m_tpb = 0;
      m_dmai = 0; m_dmao = 0; m_ack = 0; m_di = 0; m_do = 0; m_iq = 0; m_mode = 2'b01;
    end else begin
      m_mode = mi;
      m_ack = 0;
      if (mi != 2'b10) begin
        ce  = CLK_EN && m_tick == T - 1;
        smp = CLK_EN && m_tick == TB;
        nk  = next_kind(m_kind, mi == 2'b00, exec_last);
        if (smp) begin m_di = !DMA_IN_N; m_do = !DMA_OUT_N; m_iq = !INT_N; end
        if (CLK_EN) begin
          m_tick = (m_tick + 1) % T;
          m_tpa = (m_tick == TA); m_tpb = (m_tick == TB);
        end
        if (ce) begin
          m_kind = nk;
          m_dmai = (nk == K_DMAI); m_dmao = (nk == K_DMAO); m_ack = (nk == K_INT);
        end
      end
    end
  endtask

  task automatic step();
    #2;
    chk("cycle_end", {7'd0, cycle_end}, {7'd0, exp_cycle_end()});
    @(posedge CLOCK);
    model_edge();
    #1;
    chk("SC", {6'd0, SC}, {6'd0, sc_of(m_kind)});
    chk("tick", {5'd0, tick}, 8'(m_tick));
    chk("TPA", {7'd0, TPA}, {7'd0, m_tpa});
    chk("TPB", {7'd0, TPB}, {7'd0, m_tpb});
    chk("dma_in_cyc", {7'd0, dma_in_cyc}, {7'd0, m_dmai});
    chk("dma_out_cyc", {7'd0, dma_out_cyc}, {7'd0, m_dmao});
    chk("int_ack", {7'd0, int_ack}, {7'd0, m_ack});
    chk("mode", {6'd0, mode}, {6'd0, m_mode});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RESET = 1; CLK_EN = 1; CLEAR_N = 1; WAIT_N = 1; DMA_IN_N = 1; DMA_OUT_N = 1;
    INT_N = 1; IE = 0; exec_last = 1;
    @(posedge CLOCK); #1;
    step();
    chk("rst_sc", {6'd0, SC}, 8'h01);
    chk("rst_tick", {5'd0, tick}, 8'h00);
    chk("rst_mode", {6'd0, mode}, 8'h01);
    chk("rst_tpa_tpb", {6'd0, TPA, TPB}, 8'h00);
    RESET = 0;

    // one INIT cycle then fetch/execute alternation
    run(8); chk("init_to_fetch", {6'd0, SC}, 8'h00);
    run(8); chk("fetch_to_exec", {6'd0, SC}, 8'h01);
    exec_last = 0; run(8); chk("multi_exec", {6'd0, SC}, 8'h01);
    exec_last = 1; run(8); chk("exec_done", {6'd0, SC}, 8'h00);

    // DMA-in beats DMA-out, then DMA-out, then fetch
    run(8);
    DMA_IN_N = 0; DMA_OUT_N = 0; run(8);
    chk("dma_in_sc", {6'd0, SC}, 8'h02); chk("dma_in_cyc_d", {7'd0, dma_in_cyc}, 8'h01);
    DMA_IN_N = 1; run(8);
    chk("dma_out_sc", {6'd0, SC}, 8'h02); chk("dma_out_cyc_d", {7'd0, dma_out_cyc}, 8'h01);
    DMA_OUT_N = 1; run(8); chk("dma_drained", {6'd0, SC}, 8'h00);

    // interrupt taken with IE, ignored without
    run(8);
    INT_N = 0; IE = 1; run(8);
    chk("int_sc", {6'd0, SC}, 8'h03); chk("int_ack_hi", {7'd0, int_ack}, 8'h01);
    INT_N = 1; run(1); chk("int_ack_lo", {7'd0, int_ack}, 8'h00);
    run(7); chk("int_to_fetch", {6'd0, SC}, 8'h00);
    run(8);
    INT_N = 0; IE = 0; run(8); chk("int_masked", {6'd0, SC}, 8'h00);
    INT_N = 1;

    // pause mid-cycle, then a mode reset mid-cycle
    run(3);
    WAIT_N = 0; run(20); chk("pause_tick", {5'd0, tick}, 8'h03);
    WAIT_N = 1; run(1); chk("resume_tick", {5'd0, tick}, 8'h04);
    run(1);
    CLEAR_N = 0; run(1);
    chk("mreset_sc", {6'd0, SC}, 8'h01); chk("mreset_tick", {5'd0, tick}, 8'h00);
    CLEAR_N = 1; run(8); chk("after_mreset", {6'd0, SC}, 8'h00);

    // load mode: DMA-in only, interrupts ignored, never fetch
    CLEAR_N = 0; WAIT_N = 0; DMA_IN_N = 0; INT_N = 0; IE = 1;
    run(8); chk("load_dma1", {6'd0, SC}, 8'h02); chk("load_dma_cyc", {7'd0, dma_in_cyc}, 8'h01);
    run(8); chk("load_dma2", {6'd0, SC}, 8'h02);
    DMA_IN_N = 1; run(8); chk("load_idle1", {6'd0, SC}, 8'h01);
    run(8); chk("load_idle2", {6'd0, SC}, 8'h01);
    INT_N = 1; CLEAR_N = 1; WAIT_N = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      CLK_EN = ($urandom_range(0, 3) != 0);
      exec_last = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        DMA_IN_N  = ($urandom_range(0, 3) != 0);
        DMA_OUT_N = ($urandom_range(0, 2) != 0);
        INT_N     = $urandom_range(0, 1);
        IE        = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: {CLEAR_N, WAIT_N} = 2'b11;
          3:       {CLEAR_N, WAIT_N} = 2'b10;
          4:       {CLEAR_N, WAIT_N} = 2'b00;
          default: {CLEAR_N, WAIT_N} = 2'b01;
        endcase
      end
      RESET = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
